// File: rtl/shift_add_mult_ctrl.sv
// Moore sequencer for an N-bit shift-add multiplier built from registered mux cells.
// Every output except add_en comes straight from a flop, so no decode glitch reaches the datapath.
module shift_add_mult_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic CLK,
  input  logic CLR,
  input  logic start,
  input  logic q0,
  output logic m_ld,
  output logic q_ld,
  output logic q_src,
  output logic a_ld,
  output logic a_clr,
  output logic add_en,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          m_ld_q;
  logic          q_ld_q;
  logic          q_src_q;
  logic          a_ld_q;
  logic          a_clr_q;
  logic          busy_q;
  logic          done_q;

  always_comb cnt_d = cnt_q + CW'(1);

  // Output flops hold the values belonging to the state being entered.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_ld_q  <= 1'b0;
      q_ld_q  <= 1'b0;
      q_src_q <= 1'b0;
      a_ld_q  <= 1'b0;
      a_clr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      m_ld_q  <= 1'b0;
      q_ld_q  <= 1'b0;
      q_src_q <= 1'b0;
      a_ld_q  <= 1'b0;
      a_clr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            m_ld_q  <= 1'b1;
            q_ld_q  <= 1'b1;
            a_clr_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= RUN;
          cnt_q   <= '0;
          a_ld_q  <= 1'b1;
          q_ld_q  <= 1'b1;
          q_src_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        RUN: begin
          if (cnt_q == LAST) begin
            // Return the counter to zero rather than letting it reach N.
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
            a_ld_q  <= 1'b1;
            q_ld_q  <= 1'b1;
            q_src_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_ld   = m_ld_q;
  assign q_ld   = q_ld_q;
  assign q_src  = q_src_q;
  assign a_ld   = a_ld_q;
  assign a_clr  = a_clr_q;
  assign busy   = busy_q;
  assign done   = done_q;
  // a_ld_q is high exactly during RUN, so it gates the live multiplier bit.
  assign add_en = a_ld_q & q0;

endmodule
